// File: rtl/bcd_to_bin_32_pkg.sv
// Shared BCD definitions: FSM encoding, digit limits and default sizing
// used by the BCD-to-binary converter and the BCD counter bank.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;
    localparam int          DIGITS_DEF  = 8;
    localparam int          BIN_W_DEF   = 27;

endpackage : bcd_pkg

// File: rtl/bcd_to_bin_32_if.sv
// Start/busy/done request bus of the BCD-to-binary converter.
interface bcd_to_bin_32_if #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output err,
        output bin_out
    );
endinterface : bcd_to_bin_32_if

// File: rtl/bcd_to_bin_32_digit_mac.sv
// One decimal accumulate step: acc*10 + digit, with an illegal-digit flag.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic [BIN_W-1:0]       acc_i,
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BIN_W-1:0]       acc_o,
    output logic                   digit_err_o
);

    logic [BIN_W+3:0] ext_s;
    logic [BIN_W+3:0] sum_s;

    // acc*10 as (acc<<3)+(acc<<1), four guard bits before truncation
    always_comb begin
        ext_s       = {4'b0000, acc_i};
        sum_s       = (ext_s << 2'd3) + (ext_s << 2'd1) + {{BIN_W{1'b0}}, digit_i};
        acc_o       = sum_s[BIN_W-1:0];
        digit_err_o = (digit_i > BCD_MAX);
    end

endmodule : bcd_digit_mac

// File: rtl/bcd_to_bin_32.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
module bcd_to_bin_32
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_32_if.slave   bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = BCD_DIGIT_W * DIGITS;

    state_t             state_q,    state_d;
    logic [WORD_W-1:0]  bcd_in_q,   bcd_in_d;
    logic [BIN_W-1:0]   acc_q,      acc_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic               err_int_q,  err_int_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic [BIN_W-1:0]   bin_out_q,  bin_out_d;

    logic [BCD_DIGIT_W-1:0] digit_s;
    logic [BIN_W-1:0]       mac_acc_s;
    logic                   mac_err_s;
    logic                   fin_err_s;

    // Select the nibble addressed by the digit index
    always_comb begin
        digit_s = bcd_in_q[{idx_q, 2'b00} +: BCD_DIGIT_W];
    end

    bcd_digit_mac #(
        .BIN_W       (BIN_W)
    ) u_mac (
        .acc_i       (acc_q),
        .digit_i     (digit_s),
        .acc_o       (mac_acc_s),
        .digit_err_o (mac_err_s)
    );

    // Next-state and datapath updates; done is a single-cycle pulse
    always_comb begin
        state_d   = state_q;
        bcd_in_d  = bcd_in_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        err_int_d = err_int_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bin_out_d = bin_out_q;
        fin_err_s = err_int_q | mac_err_s;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_CONV;
                    bcd_in_d  = bus.bcd_in;
                    acc_d     = {BIN_W{1'b0}};
                    idx_d     = IDX_W'(DIGITS - 1);
                    err_int_d = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            ST_CONV: begin
                acc_d     = mac_acc_s;
                err_int_d = fin_err_s;
                if (idx_q == {IDX_W{1'b0}}) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = fin_err_s;
                    bin_out_d = fin_err_s ? {BIN_W{1'b0}} : mac_acc_s;
                end else begin
                    idx_d     = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bcd_in_q  <= {WORD_W{1'b0}};
            acc_q     <= {BIN_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            err_int_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_out_q <= {BIN_W{1'b0}};
        end else begin
            state_q   <= state_d;
            bcd_in_q  <= bcd_in_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            err_int_q <= err_int_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_out_q <= bin_out_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_out_q;

endmodule : bcd_to_bin_32

// File: tb/tb_bcd_to_bin_32.sv
// Self-checking bench for bcd_to_bin_32: directed cases plus randomized
// words checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin_32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    bcd_to_bin_32_if #(.DIGITS(8), .BIN_W(27)) bus ();

    bcd_to_bin_32 #(.DIGITS(8), .BIN_W(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the nibbles, or error if any nibble exceeds 9
    task automatic model(input logic [31:0] w, output longint val, output bit bad);
        longint weight = 1;
        logic [31:0] t = w;
        val = 0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int d = int'(t % 16);
            t = t / 16;
            if (d > 9) bad = 1'b1;
            val += d * weight;
            weight *= 10;
        end
        if (bad) val = 0;
    endtask

    // Wait for done at negedges; returns cycles waited and busy cycles seen
    task automatic wait_done(input int start_lat, output int lat, output int bc, output bit ovl);
        lat = start_lat;
        bc  = 0;
        ovl = 1'b0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) bc++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) ovl = 1'b1;
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] w);
        longint ev;
        bit     ee;
        int     lat, bc;
        bit     ovl;
        model(w, ev, ee);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = w;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = $urandom;
        check_val({tag, "_err_clr"}, bus.err, 0);
        wait_done(1, lat, bc, ovl);
        bc += 1;
        check_val({tag, "_lat"}, lat, 9);
        check_val({tag, "_busy_cyc"}, bc, 8);
        check_val({tag, "_ovl"}, ovl, 0);
        check_val({tag, "_bin"}, bus.bin_out, ev);
        check_val({tag, "_err"}, bus.err, ee);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, bus.done, 0);
        check_val({tag, "_bin_hold"}, bus.bin_out, ev);
    endtask

    initial begin
        int lat, bc;
        bit ovl;
        logic [31:0] w;

        bus.start  = 1'b0;
        bus.bcd_in = 32'h0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_bin", bus.bin_out, 0);
        rst = 1'b0;

        convert("zero", 32'h00000000);
        convert("mid", 32'h12345678);
        convert("max", 32'h99999999);
        convert("bad", 32'h1234A678);
        convert("after_bad", 32'h00000042);

        // start during busy is ignored; start in done cycle is accepted
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h00000005;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (2) @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h00000777;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(4, lat, bc, ovl);
        check_val("ign_lat", lat, 9);
        check_val("ign_bin", bus.bin_out, 5);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h00000777;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(1, lat, bc, ovl);
        check_val("b2b_lat", lat, 9);
        check_val("b2b_bin", bus.bin_out, 777);

        // start held high: a new result every DIGITS+1 cycles
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h00000314;
        @(negedge clk);
        wait_done(1, lat, bc, ovl);
        check_val("hold_lat1", lat, 9);
        @(negedge clk);
        wait_done(1, lat, bc, ovl);
        check_val("hold_lat2", lat, 9);
        check_val("hold_bin", bus.bin_out, 314);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        // reset mid-conversion aborts with no done
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 32'h87654321;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_bin", bus.bin_out, 0);
        check_val("abort_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) lat++;
        end
        check_val("abort_no_done", lat, 0);
        convert("fresh", 32'h87654321);

        // randomized words, occasionally with an illegal nibble
        for (int k = 0; k < 24; k++) begin
            w = 32'h0;
            for (int i = 0; i < 8; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 7)*4 +: 4] = 4'($urandom_range(10, 15));
            convert($sformatf("rnd%0d", k), w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_bcd_to_bin_32
